tri_fu_csa_acc: RTL

Carry-save accumulator and pipelined resolve stage for the FU multiplier datapath. It consumes the redundant sum/carry vector pairs produced by the half-adder/compressor tree, folds successive pairs into a carry-save accumulator across a multi-beat operation, and resolves the final redundant pair into a binary result through a two-stage split carry-propagate adder. It sits directly downstream of the compressor tree and feeds the normalizer/rounder.

---
 rtl/tri_fu_csa_acc_pkg.sv | 13 +
 rtl/tri_fu_csa42.sv | 31 +++
 rtl/tri_fu_csa_acc.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tri_fu_csa_acc_pkg.sv
// Shared FU constants for the carry-save accumulator slice.
// Holds the default datapath/counter widths and the accumulator FSM encoding.
package tri_fu_csa_acc_pkg;

  // Default datapath width (even, at least 8) and beat-counter width
  localparam int TRI_FU_WIDTH = 64;
  localparam int TRI_FU_CNT_W = 8;

  // Accumulator FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

endpackage

// File: rtl/tri_fu_csa42.sv
// Vector 4:2 compressor built from two cascaded 3:2 cell rows.
// Returns a sum vector and a carry vector that is already shifted left by
// one; the carry leaving the top bit is dropped, so o_sum + o_car equals
// i_a + i_b + i_c + i_d modulo 2^WIDTH.
module tri_fu_csa42 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_car
);

  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_m1;
  logic [WIDTH-1:0] w_c1;
  logic [WIDTH-1:0] w_m2;

  // First 3:2 row: a, b, c per bit
  assign w_s1 = i_a ^ i_b ^ i_c;
  assign w_m1 = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign w_c1 = {w_m1[WIDTH-2:0], 1'b0};

  // Second 3:2 row: first-row sum, d and the first-row carry from bit i-1
  assign o_sum = w_s1 ^ i_d ^ w_c1;
  assign w_m2  = (w_s1 & i_d) | (w_s1 & w_c1) | (i_d & w_c1);
  assign o_car = {w_m2[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/tri_fu_csa_acc.sv
// Carry-save accumulator with a two-stage split carry-propagate resolve.
// Beats of redundant (sum, carry) pairs are folded with a 4:2 compressor;
// the beat flagged last is snapshotted into the resolve pipeline, which adds
// the low half in stage 1 and the high half plus carry in stage 2.
module tri_fu_csa_acc
  import tri_fu_csa_acc_pkg::*;
#(
  parameter int WIDTH = TRI_FU_WIDTH,
  parameter int CNT_W = TRI_FU_CNT_W
) (
  input  logic             nclk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             in_vld,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_car,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_abort
);

  localparam int HALF = WIDTH / 2;

  // Accumulator state
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc_sum;
  logic [WIDTH-1:0] r_acc_car;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;

  // Resolve stage 1 registers
  logic             r_s1_vld;
  logic [HALF-1:0]  r_s1_lo;
  logic             r_s1_c;
  logic [HALF-1:0]  r_s1_hs;
  logic [HALF-1:0]  r_s1_hc;
  logic [CNT_W-1:0] r_s1_cnt;

  // Resolve stage 2 (output) registers
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_res;
  logic             r_out_zero;
  logic [CNT_W-1:0] r_out_cnt;

  logic [WIDTH-1:0] w_csa_sum;
  logic [WIDTH-1:0] w_csa_car;
  logic             w_beat;
  logic             w_start;
  logic [WIDTH-1:0] w_nxt_sum;
  logic [WIDTH-1:0] w_nxt_car;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [HALF:0]    w_lo;
  logic [HALF-1:0]  w_hi;
  logic [WIDTH-1:0] w_res;

  tri_fu_csa42 #(
    .WIDTH (WIDTH)
  ) u_csa42 (
    .i_a   (r_acc_sum),
    .i_b   (r_acc_car),
    .i_c   (in_sum),
    .i_d   (in_car),
    .o_sum (w_csa_sum),
    .o_car (w_csa_car)
  );

  // A beat coinciding with flush is dropped; any beat in IDLE acts as first
  assign w_beat  = in_vld & ~flush;
  assign w_start = (r_state == ST_IDLE) | in_first;

  // Next accumulator value: load on a starting beat, otherwise compress in
  always_comb begin
    w_nxt_sum = r_acc_sum;
    w_nxt_car = r_acc_car;
    w_nxt_cnt = r_cnt;
    if (w_start) begin
      w_nxt_sum = in_sum;
      w_nxt_car = in_car;
      w_nxt_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_nxt_sum = w_csa_sum;
      w_nxt_car = w_csa_car;
      if (r_cnt == {CNT_W{1'b1}}) begin
        w_nxt_cnt = r_cnt;
      end else begin
        w_nxt_cnt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Split carry-propagate adder halves
  assign w_lo  = {1'b0, w_nxt_sum[HALF-1:0]} + {1'b0, w_nxt_car[HALF-1:0]};
  assign w_hi  = r_s1_hs + r_s1_hc + {{(HALF-1){1'b0}}, r_s1_c};
  assign w_res = {w_hi, r_s1_lo};

  // FSM: open on a non-last beat, close on a last beat or flush
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else if (in_vld) begin
      r_state <= in_last ? ST_IDLE : ST_ACC;
    end else begin
      r_state <= r_state;
    end
  end

  // Accumulator registers and beat counter
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      r_acc_sum <= {WIDTH{1'b0}};
      r_acc_car <= {WIDTH{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
    end else if (w_beat) begin
      r_acc_sum <= w_nxt_sum;
      r_acc_car <= w_nxt_car;
      r_cnt     <= w_nxt_cnt;
    end
  end

  // Abort pulse when in_first discards an open accumulation
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_beat & in_first & (r_state == ST_ACC);
    end
  end

  // Resolve stage 1: snapshot the updated pair, add the low half
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      r_s1_vld <= 1'b0;
      r_s1_lo  <= {HALF{1'b0}};
      r_s1_c   <= 1'b0;
      r_s1_hs  <= {HALF{1'b0}};
      r_s1_hc  <= {HALF{1'b0}};
      r_s1_cnt <= {CNT_W{1'b0}};
    end else begin
      r_s1_vld <= w_beat & in_last;
      if (w_beat & in_last) begin
        r_s1_lo  <= w_lo[HALF-1:0];
        r_s1_c   <= w_lo[HALF];
        r_s1_hs  <= w_nxt_sum[WIDTH-1:HALF];
        r_s1_hc  <= w_nxt_car[WIDTH-1:HALF];
        r_s1_cnt <= w_nxt_cnt;
      end
    end
  end

  // Resolve stage 2: add the high half with carry-in, hold data when idle
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      r_out_vld  <= 1'b0;
      r_out_res  <= {WIDTH{1'b0}};
      r_out_zero <= 1'b0;
      r_out_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_out_vld <= r_s1_vld & ~flush;
      if (r_s1_vld & ~flush) begin
        r_out_res  <= w_res;
        r_out_zero <= (w_res == {WIDTH{1'b0}});
        r_out_cnt  <= r_s1_cnt;
      end
    end
  end

  assign out_vld   = r_out_vld;
  assign out_res   = r_out_res;
  assign out_zero  = r_out_zero;
  assign out_cnt   = r_out_cnt;
  assign out_abort = r_abort;

endmodule
